single_cycle_cpu: RTL and testbench

//  32-bit MIPS-subset single-cycle CPU: R-type ALU, I-type ALU, lw/sw; no branches/jumps.
//  One instruction retires per rising clock edge; fetch, decode, execute and memory are combinational.

---
 rtl/single_cycle_cpu.sv | 210 +++++++++++++++++++++
 tb/tb_single_cycle_cpu.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/single_cycle_cpu.sv
// ---------------------------------------------------------------------------
// single_cycle_cpu
//   32-bit MIPS-subset single-cycle CPU. It supports R-type ALU ops, I-type ALU
//   ops, lw and sw. There are no branches or jumps. Fetch, decode, execute and
//   memory access are combinational, and one instruction retires on every
//   rising clock edge.
//   Instruction memory (IM.ins_memory) and data memory (DM.data_memory) live
//   inside this top. Reset does not touch either memory.
// Ports
//   clock : system clock; all state updates on the rising edge
//   reset : asynchronous, active-low reset (clears PC and the register file)
// ---------------------------------------------------------------------------

// Instruction memory: combinational read. The write port is for loaders and is
// tied off by the CPU top.
module scc_imem #(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata_c
);
   logic [31:0] ins_memory [DEPTH];

   // Optional load port
   always_ff @(posedge clk) begin
      if (we) ins_memory[waddr] <= wdata;
   end

   assign rdata_c = ins_memory[raddr];
endmodule

// Data memory: combinational read, write on the rising edge.
module scc_dmem #(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata_c
);
   logic [31:0] data_memory [DEPTH];

   // Word write
   always_ff @(posedge clk) begin
      if (we) data_memory[addr] <= wdata;
   end

   assign rdata_c = data_memory[addr];
endmodule

module single_cycle_cpu #(
   parameter int unsigned IM_DEPTH = 256,
   parameter int unsigned DM_DEPTH = 256
) (
   input  logic clock,
   input  logic reset
);
   localparam int unsigned IM_AW = $clog2(IM_DEPTH);
   localparam int unsigned DM_AW = $clog2(DM_DEPTH);
   localparam int unsigned NREGS = 32;

   // Opcodes
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // R-type function codes
   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A;
   localparam logic [5:0] FN_SLTU = 6'h2B;

   logic [31:0] pc_q, pc_d;
   logic [31:0] rf_q [NREGS];
   logic [31:0] rf_d [NREGS];

   logic [31:0] instr_c;
   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd, shamt;
   logic [15:0] imm;
   logic [31:0] rs_val, rt_val, imm_sext, imm_zext;
   logic [31:0] mem_addr, mem_rdata_c;
   logic        reg_we, mem_we;
   logic [4:0]  reg_waddr;
   logic [31:0] reg_wdata;
   logic        unused_mem_addr;

   // Fetch: the index wraps modulo IM_DEPTH
   scc_imem #(.DEPTH(IM_DEPTH)) IM (
      .clk     (clock),
      .we      (1'b0),
      .waddr   ('0),
      .wdata   ('0),
      .raddr   (pc_q[IM_AW+1:2]),
      .rdata_c (instr_c)
   );

   // Field decode
   assign opcode = instr_c[31:26];
   assign rs     = instr_c[25:21];
   assign rt     = instr_c[20:16];
   assign rd     = instr_c[15:11];
   assign shamt  = instr_c[10:6];
   assign funct  = instr_c[5:0];
   assign imm    = instr_c[15:0];

   assign imm_sext = {{16{imm[15]}}, imm};
   assign imm_zext = {16'h0000, imm};

   // Register reads; $0 always reads zero
   assign rs_val = (rs == 5'd0) ? 32'd0 : rf_q[rs];
   assign rt_val = (rt == 5'd0) ? 32'd0 : rf_q[rt];

   // Effective address. Byte-offset and high bits are ignored, so access wraps modulo DM_DEPTH.
   assign mem_addr        = rs_val + imm_sext;
   assign unused_mem_addr = ^{mem_addr[31:DM_AW+2], mem_addr[1:0]};

   // Block writes while reset is low
   scc_dmem #(.DEPTH(DM_DEPTH)) DM (
      .clk     (clock),
      .we      (mem_we & reset),
      .addr    (mem_addr[DM_AW+1:2]),
      .wdata   (rt_val),
      .rdata_c (mem_rdata_c)
   );

   // Execute / writeback select
   always_comb begin
      reg_we    = 1'b0;
      mem_we    = 1'b0;
      reg_waddr = rt;
      reg_wdata = 32'd0;
      case (opcode)
         OP_RTYPE: begin
            reg_waddr = rd;
            reg_we    = 1'b1;
            case (funct)
               FN_ADD,
               FN_ADDU: reg_wdata = rs_val + rt_val;
               FN_SUB,
               FN_SUBU: reg_wdata = rs_val - rt_val;
               FN_AND:  reg_wdata = rs_val & rt_val;
               FN_OR:   reg_wdata = rs_val | rt_val;
               FN_XOR:  reg_wdata = rs_val ^ rt_val;
               FN_NOR:  reg_wdata = ~(rs_val | rt_val);
               FN_SLT:  reg_wdata = {31'd0, $signed(rs_val) < $signed(rt_val)};
               FN_SLTU: reg_wdata = {31'd0, rs_val < rt_val};
               FN_SLL:  reg_wdata = rt_val << shamt;
               FN_SRL:  reg_wdata = rt_val >> shamt;
               FN_SRA:  reg_wdata = 32'($signed(rt_val) >>> shamt);
               default: reg_we    = 1'b0;
            endcase
         end
         OP_ADDI,
         OP_ADDIU: begin reg_we = 1'b1; reg_wdata = rs_val + imm_sext; end
         OP_SLTI:  begin reg_we = 1'b1; reg_wdata = {31'd0, $signed(rs_val) < $signed(imm_sext)}; end
         OP_SLTIU: begin reg_we = 1'b1; reg_wdata = {31'd0, rs_val < imm_sext}; end
         OP_ANDI:  begin reg_we = 1'b1; reg_wdata = rs_val & imm_zext; end
         OP_ORI:   begin reg_we = 1'b1; reg_wdata = rs_val | imm_zext; end
         OP_XORI:  begin reg_we = 1'b1; reg_wdata = rs_val ^ imm_zext; end
         OP_LUI:   begin reg_we = 1'b1; reg_wdata = {imm, 16'h0000}; end
         OP_LW:    begin reg_we = 1'b1; reg_wdata = mem_rdata_c; end
         OP_SW:    mem_we = 1'b1;
         default:  ;
      endcase
   end

   // Next state: PC advances every cycle; $0 is forced back to zero
   always_comb begin
      pc_d = pc_q + 32'd4;
      for (int i = 0; i < 32; i++) rf_d[i] = rf_q[i];
      if (reg_we) rf_d[reg_waddr] = reg_wdata;
      rf_d[0] = 32'd0;
   end

   // Architectural state
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pc_q <= 32'd0;
         for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
      end else begin
         pc_q <= pc_d;
         for (int i = 0; i < 32; i++) rf_q[i] <= rf_d[i];
      end
   end
endmodule

// File: tb/tb_single_cycle_cpu.sv
// ---------------------------------------------------------------------------
// tb_single_cycle_cpu
//   Directed bench for single_cycle_cpu. Programs are preloaded hierarchically
//   into IM/DM. Results are read from the register file, the PC and DM, and
//   compared against hand-computed values.
// ---------------------------------------------------------------------------
module tb_single_cycle_cpu;
   logic clock;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   single_cycle_cpu #(.IM_DEPTH(256), .DM_DEPTH(256)) dut (
      .clock (clock),
      .reset (reset)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // ALU program: each instruction writes register (index+1)
   logic [31:0] alu_prog [0:17] = '{
      32'h20010064, 32'h2002fffd, 32'h00221822, 32'h00222025, 32'h00222826, 32'h00223027,
      32'h00223824, 32'h00414023, 32'h2849fffe, 32'h2c2affff, 32'h304bffff, 32'h382c00ff,
      32'h244d8000, 32'h3c0e7fff, 32'h01ce7820, 32'h00228021, 32'h0041882b, 32'h0041902a};
   logic [31:0] alu_exp [0:17] = '{
      32'h00000064, 32'hFFFFFFFD, 32'h00000067, 32'hFFFFFFFD, 32'hFFFFFF99, 32'h00000002,
      32'h00000064, 32'hFFFFFF99, 32'h00000001, 32'h00000001, 32'h0000FFFD, 32'h0000009B,
      32'hFFFF7FFD, 32'h7FFF0000, 32'hFFFE0000, 32'h00000061, 32'h00000000, 32'h00000001};

   task automatic set_im(input int idx, input logic [31:0] w);
      dut.IM.ins_memory[idx] = w;
   endtask

   task automatic set_dm(input int idx, input logic [31:0] w);
      dut.DM.data_memory[idx] = w;
   endtask

   task automatic clear_mems();
      for (int i = 0; i < 256; i++) begin
         dut.IM.ins_memory[i]  = 32'h0;
         dut.DM.data_memory[i] = 32'h0;
      end
   endtask

   // Put the core in reset and wipe memories so a new program can be loaded
   task automatic restart();
      @(negedge clock);
      reset = 1'b0;
      #1;
      clear_mems();
   endtask

   task automatic go();
      @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic run(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic load_ls_prog();
      set_dm(1, 32'd1234);
      set_dm(2, 32'd2683);
      set_im(0, 32'h8c010004);
      set_im(1, 32'h8c020008);
      set_im(2, 32'h00221820);
      set_im(3, 32'hac03000c);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      clear_mems();
      load_ls_prog();
      #1;
      checks++;
      if (dut.pc_q !== 32'd0) begin
         errors++; $display("FAIL reset_pc got %h want %h", dut.pc_q, 32'd0);
      end
      for (int r = 0; r < 4; r++) begin
         checks++;
         if (dut.rf_q[r] !== 32'd0) begin
            errors++; $display("FAIL reset_gpr%0d got %h want %h", r, dut.rf_q[r], 32'd0);
         end
      end
   endtask

   // Reset is released at t=10 and results are sampled at t=100
   task automatic test_load_store();
      #9;
      reset = 1'b1;
      #90;
      checks++;
      if (dut.DM.data_memory[3] !== 32'd3917) begin
         errors++; $display("FAIL ls_dm3 got %0d want %0d", dut.DM.data_memory[3], 3917);
      end
      checks++;
      if (dut.DM.data_memory[1] !== 32'd1234 || dut.DM.data_memory[2] !== 32'd2683) begin
         errors++; $display("FAIL ls_dm12 got %0d/%0d want 1234/2683",
                            dut.DM.data_memory[1], dut.DM.data_memory[2]);
      end
      checks++;
      if (dut.rf_q[3] !== 32'd3917) begin
         errors++; $display("FAIL ls_gpr3 got %0d want %0d", dut.rf_q[3], 3917);
      end
      checks++;
      if (dut.pc_q !== 32'd36) begin
         errors++; $display("FAIL ls_pc got %0d want %0d", dut.pc_q, 36);
      end
   endtask

   // While reset is low, a sw sitting at PC 0 must not commit
   task automatic test_reset_blocks_write();
      restart();
      set_dm(3, 32'h1111);
      set_im(0, 32'hac03000c);
      run(3);
      checks++;
      if (dut.DM.data_memory[3] !== 32'h1111 || dut.pc_q !== 32'd0) begin
         errors++; $display("FAIL rst_nowrite got dm3=%h pc=%h want 00001111/0",
                            dut.DM.data_memory[3], dut.pc_q);
      end
      go();
      run(1);
      checks++;
      if (dut.DM.data_memory[3] !== 32'h0 || dut.pc_q !== 32'd4) begin
         errors++; $display("FAIL rst_release got dm3=%h pc=%h want 0/4",
                            dut.DM.data_memory[3], dut.pc_q);
      end
   endtask

   task automatic test_slt();
      restart();
      set_im(0, 32'h2001ffff);
      set_im(1, 32'h0001102b);
      set_im(2, 32'h0001182a);
      go();
      run(3);
      checks++;
      if (dut.rf_q[1] !== 32'hFFFFFFFF) begin
         errors++; $display("FAIL slt_gpr1 got %h want FFFFFFFF", dut.rf_q[1]);
      end
      checks++;
      if (dut.rf_q[2] !== 32'd1) begin
         errors++; $display("FAIL sltu_gpr2 got %h want 00000001", dut.rf_q[2]);
      end
      checks++;
      if (dut.rf_q[3] !== 32'd0) begin
         errors++; $display("FAIL slt_gpr3 got %h want 00000000", dut.rf_q[3]);
      end
   endtask

   task automatic test_shift_logic();
      logic [31:0] exp_v [0:4];
      int          exp_r [0:4];
      restart();
      set_im(0, 32'h3c041234);   // lui  $4,0x1234
      set_im(1, 32'h34848765);   // ori  $4,$4,0x8765
      set_im(2, 32'h3c078000);   // lui  $7,0x8000
      set_im(3, 32'h00072903);   // sra  $5,$7,4
      set_im(4, 32'h00074102);   // srl  $8,$7,4
      set_im(5, 32'h00044a00);   // sll  $9,$4,8
      set_im(6, 32'h00045103);   // sra  $10,$4,4
      exp_r = '{4, 5, 8, 9, 10};
      exp_v = '{32'h12348765, 32'hF8000000, 32'h08000000, 32'h34876500, 32'h01234876};
      go();
      run(7);
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (dut.rf_q[exp_r[k]] !== exp_v[k]) begin
            errors++; $display("FAIL shift_gpr%0d got %h want %h", exp_r[k], dut.rf_q[exp_r[k]], exp_v[k]);
         end
      end
   endtask

   task automatic test_zero_reg();
      restart();
      set_im(0, 32'h20060007);   // addi $6,$0,7
      set_im(1, 32'h20000005);   // addi $0,$0,5
      set_im(2, 32'h00003020);   // add  $6,$0,$0
      go();
      run(2);
      checks++;
      if (dut.rf_q[0] !== 32'd0 || dut.rf_q[6] !== 32'd7) begin
         errors++; $display("FAIL zero_gpr0 got r0=%h r6=%h want 0/7", dut.rf_q[0], dut.rf_q[6]);
      end
      run(1);
      checks++;
      if (dut.rf_q[6] !== 32'd0) begin
         errors++; $display("FAIL zero_gpr6 got %h want 00000000", dut.rf_q[6]);
      end
   endtask

   task automatic test_undefined();
      restart();
      set_dm(0, 32'h77);
      set_im(0, 32'hfc21ffff);   // undefined opcode 0x3F
      set_im(1, 32'h20010009);   // addi $1,$0,9
      set_im(2, 32'h20030003);   // addi $3,$0,3
      set_im(3, 32'h0021183f);   // R-type, undefined funct, rd=$3
      go();
      run(1);
      checks++;
      if (dut.pc_q !== 32'd4 || dut.rf_q[1] !== 32'd0 || dut.DM.data_memory[0] !== 32'h77) begin
         errors++; $display("FAIL undef_op got pc=%h r1=%h dm0=%h want 4/0/77",
                            dut.pc_q, dut.rf_q[1], dut.DM.data_memory[0]);
      end
      run(3);
      checks++;
      if (dut.rf_q[1] !== 32'd9 || dut.rf_q[3] !== 32'd3 || dut.pc_q !== 32'd16) begin
         errors++; $display("FAIL undef_funct got r1=%h r3=%h pc=%h want 9/3/10",
                            dut.rf_q[1], dut.rf_q[3], dut.pc_q);
      end
   endtask

   task automatic test_alu();
      restart();
      for (int k = 0; k < 18; k++) set_im(k, alu_prog[k]);
      go();
      run(18);
      for (int k = 0; k < 18; k++) begin
         checks++;
         if (dut.rf_q[k+1] !== alu_exp[k]) begin
            errors++; $display("FAIL alu_gpr%0d got %h want %h", k + 1, dut.rf_q[k+1], alu_exp[k]);
         end
      end
   endtask

   task automatic test_mem_wrap();
      restart();
      set_dm(0, 32'hCAFEF00D);
      set_dm(2, 32'h000055AA);
      set_im(0, 32'h2001fffc);   // addi $1,$0,-4
      set_im(1, 32'hac210000);   // sw $1,0($1)     -> DM[255]
      set_im(2, 32'h8c020003);   // lw $2,3($0)     -> DM[0]
      set_im(3, 32'h8c030408);   // lw $3,0x408($0) -> DM[2]
      set_im(4, 32'hac010404);   // sw $1,0x404($0) -> DM[1]
      go();
      run(5);
      checks++;
      if (dut.DM.data_memory[255] !== 32'hFFFFFFFC) begin
         errors++; $display("FAIL wrap_dm255 got %h want FFFFFFFC", dut.DM.data_memory[255]);
      end
      checks++;
      if (dut.rf_q[2] !== 32'hCAFEF00D) begin
         errors++; $display("FAIL unaligned_lw got %h want CAFEF00D", dut.rf_q[2]);
      end
      checks++;
      if (dut.rf_q[3] !== 32'h000055AA) begin
         errors++; $display("FAIL wrap_lw got %h want 000055AA", dut.rf_q[3]);
      end
      checks++;
      if (dut.DM.data_memory[1] !== 32'hFFFFFFFC || dut.DM.data_memory[0] !== 32'hCAFEF00D) begin
         errors++; $display("FAIL wrap_sw got dm1=%h dm0=%h want FFFFFFFC/CAFEF00D",
                            dut.DM.data_memory[1], dut.DM.data_memory[0]);
      end
   endtask

   task automatic test_reset_mid();
      restart();
      load_ls_prog();
      go();
      run(2);
      checks++;
      if (dut.rf_q[1] !== 32'd1234 || dut.rf_q[2] !== 32'd2683) begin
         errors++; $display("FAIL mid_pre got r1=%0d r2=%0d want 1234/2683", dut.rf_q[1], dut.rf_q[2]);
      end
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if (dut.pc_q !== 32'd0 || dut.rf_q[1] !== 32'd0 || dut.rf_q[2] !== 32'd0) begin
         errors++; $display("FAIL mid_async got pc=%h r1=%h r2=%h want 0/0/0",
                            dut.pc_q, dut.rf_q[1], dut.rf_q[2]);
      end
      run(1);
      checks++;
      if (dut.DM.data_memory[1] !== 32'd1234 || dut.DM.data_memory[2] !== 32'd2683 ||
          dut.DM.data_memory[3] !== 32'd0 || dut.pc_q !== 32'd0) begin
         errors++; $display("FAIL mid_hold got dm1=%0d dm2=%0d dm3=%0d pc=%0d want 1234/2683/0/0",
                            dut.DM.data_memory[1], dut.DM.data_memory[2],
                            dut.DM.data_memory[3], dut.pc_q);
      end
      go();
      run(4);
      checks++;
      if (dut.DM.data_memory[3] !== 32'd3917 || dut.rf_q[3] !== 32'd3917) begin
         errors++; $display("FAIL mid_rerun got dm3=%0d r3=%0d want 3917/3917",
                            dut.DM.data_memory[3], dut.rf_q[3]);
      end
   endtask

   initial begin
      test_reset();
      test_load_store();
      test_reset_blocks_write();
      test_slt();
      test_shift_logic();
      test_zero_reg();
      test_undefined();
      test_alu();
      test_mem_wrap();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
